// File: rtl/config_frame_receiver.sv
// rtl/config_frame_receiver.sv - byte-stream config frame parser with staging/active register banks
// Frames: cmd, [addr, count, data words], checksum; COMMIT copies staging to the active bank.
module config_frame_receiver #(
  parameter int WIDTH  = 8,
  parameter int WORD   = 32,
  parameter int N_REGS = 64
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [WIDTH-1:0]       sig_in,
  input  logic                   enable,
  input  logic                   frame_start,
  output logic [N_REGS*WORD-1:0] conf_out,
  output logic                   commit_pulse,
  output logic [3:0]             status,
  output logic                   busy
);
  localparam int BPW = WORD / WIDTH;
  localparam int AW  = (N_REGS > 1) ? $clog2(N_REGS) : 1;
  localparam int BW  = (BPW > 1) ? $clog2(BPW) : 1;
  localparam logic [WIDTH:0]  NREGS_X   = (WIDTH+1)'(N_REGS);
  localparam logic [BW-1:0]   LAST_BYTE = BW'(BPW - 1);
  localparam logic [1:0]      CMD_COMMIT = 2'd2;
  localparam logic [1:0]      CMD_CLEAR  = 2'd3;

  typedef enum logic [2:0] {IDLE, ADDR, COUNT, DATA, CSUM, DISCARD} state_t;
  state_t state, state_n, cur;

  logic [WORD-1:0]  staging [N_REGS];
  logic [WORD-1:0]  active  [N_REGS];
  logic [1:0]       cmd;
  logic [AW-1:0]    wptr;
  logic [WIDTH-1:0] words_left;
  logic [BW-1:0]    byte_cnt;
  logic [WORD-1:0]  word_acc;
  logic [WORD-1:0]  word_next;
  logic [WIDTH-1:0] csum;
  logic [WIDTH:0]   idx_x;
  logic [WIDTH:0]   end_x;
  logic [3:0]       err_set;
  logic             csum_ok;
  logic             last_byte;
  logic             word_wr;
  logic             commit_go;
  logic             clear_go;

  assign idx_x     = {{(WIDTH+1-AW){1'b0}}, wptr};
  assign word_next = (word_acc << WIDTH) | WORD'(sig_in);
  assign busy      = (state != IDLE);

  for (genvar g = 0; g < N_REGS; g++) begin : g_out
    assign conf_out[g*WORD +: WORD] = active[g];
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  // frame_start restarts the parser before the coincident byte is decoded
  always_comb begin
    cur        = frame_start ? IDLE : state;
    state_n    = cur;
    err_set    = '0;
    err_set[3] = frame_start && (state != IDLE);
    csum_ok    = ((csum ^ sig_in) == '0);
    last_byte  = (byte_cnt == LAST_BYTE);
    end_x      = idx_x + {1'b0, sig_in};
    word_wr    = 1'b0;
    commit_go  = 1'b0;
    clear_go   = 1'b0;
    if (enable) begin
      case (cur)
        IDLE: begin
          if (sig_in == WIDTH'(1)) state_n = ADDR;
          else if (sig_in == WIDTH'(2) || sig_in == WIDTH'(3)) state_n = CSUM;
          else begin
            err_set[2] = 1'b1;
            state_n    = DISCARD;
          end
        end
        ADDR: begin
          if ({1'b0, sig_in} >= NREGS_X) begin
            err_set[1] = 1'b1;
            state_n    = DISCARD;
          end else state_n = COUNT;
        end
        COUNT: begin
          if (sig_in == '0 || end_x > NREGS_X) begin
            err_set[1] = 1'b1;
            state_n    = DISCARD;
          end else state_n = DATA;
        end
        DATA: begin
          if (last_byte) begin
            word_wr = 1'b1;
            if (words_left == WIDTH'(1)) state_n = CSUM;
          end
        end
        CSUM: begin
          state_n = IDLE;
          case (cmd)
            CMD_COMMIT: begin
              if (!csum_ok) err_set[0] = 1'b1;
              else if (status == 4'b0000) commit_go = 1'b1;
            end
            CMD_CLEAR: begin
              if (csum_ok) clear_go = 1'b1;
              else err_set[0] = 1'b1;
            end
            default: if (!csum_ok) err_set[0] = 1'b1;
          endcase
        end
        DISCARD: state_n = DISCARD;
        default: state_n = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N_REGS; i++) begin
        staging[i] <= '0;
        active[i]  <= '0;
      end
      cmd          <= '0;
      wptr         <= '0;
      words_left   <= '0;
      byte_cnt     <= '0;
      word_acc     <= '0;
      csum         <= '0;
      status       <= '0;
      commit_pulse <= 1'b0;
    end else begin
      commit_pulse <= commit_go;
      status       <= clear_go ? 4'b0000 : (status | err_set);
      if (frame_start) begin
        byte_cnt <= '0;
        word_acc <= '0;
      end
      if (enable) begin
        case (cur)
          IDLE: begin
            cmd      <= sig_in[1:0];
            csum     <= sig_in;
            byte_cnt <= '0;
            word_acc <= '0;
          end
          ADDR: begin
            wptr <= sig_in[AW-1:0];
            csum <= csum ^ sig_in;
          end
          COUNT: begin
            words_left <= sig_in;
            byte_cnt   <= '0;
            csum       <= csum ^ sig_in;
          end
          DATA: begin
            csum <= csum ^ sig_in;
            if (word_wr) begin
              staging[wptr] <= word_next;
              wptr          <= wptr + 1'b1;
              words_left    <= words_left - 1'b1;
              byte_cnt      <= '0;
              word_acc      <= '0;
            end else begin
              word_acc <= word_next;
              byte_cnt <= byte_cnt + 1'b1;
            end
          end
          default: ;
        endcase
      end
      if (commit_go) begin
        for (int i = 0; i < N_REGS; i++) active[i] <= staging[i];
      end
      if (clear_go) begin
        for (int i = 0; i < N_REGS; i++) staging[i] <= active[i];
      end
    end
  end
endmodule

// File: tb/tb_config_frame_receiver.sv
// tb/tb_config_frame_receiver.sv - directed self-checking bench for config_frame_receiver
// Inputs change on the falling edge; outputs are sampled on the falling edge.
module tb_config_frame_receiver;
  localparam int WIDTH  = 8;
  localparam int WORD   = 32;
  localparam int N_REGS = 16;

  logic                   clk = 1'b0;
  logic                   rst;
  logic [WIDTH-1:0]       sig_in;
  logic                   enable;
  logic                   frame_start;
  logic [N_REGS*WORD-1:0] conf_out;
  logic                   commit_pulse;
  logic [3:0]             status;
  logic                   busy;

  int tests  = 0;
  int failed = 0;

  always #5 clk = ~clk;

  config_frame_receiver #(.WIDTH(WIDTH), .WORD(WORD), .N_REGS(N_REGS)) dut (
    .clk(clk),
    .rst(rst),
    .sig_in(sig_in),
    .enable(enable),
    .frame_start(frame_start),
    .conf_out(conf_out),
    .commit_pulse(commit_pulse),
    .status(status),
    .busy(busy)
  );

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic put(input logic [7:0] b);
    sig_in = b;
    enable = 1'b1;
    @(negedge clk);
    enable = 1'b0;
  endtask

  task automatic put_fs(input logic [7:0] b);
    frame_start = 1'b1;
    sig_in      = b;
    enable      = 1'b1;
    @(negedge clk);
    frame_start = 1'b0;
    enable      = 1'b0;
  endtask

  task automatic fs();
    frame_start = 1'b1;
    @(negedge clk);
    frame_start = 1'b0;
  endtask

  logic [7:0] bulk [18];

  initial begin
    rst = 1'b1; enable = 1'b0; frame_start = 1'b0; sig_in = '0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_conf_out", conf_out, '0);
    chk("rst_status", status, 4'b0000);
    chk("rst_busy", busy, 1'b0);
    chk("rst_commit", commit_pulse, 1'b0);
    rst = 1'b0;
    @(negedge clk);

    // write 0xDEADBEEF into reg 3, then commit
    fs();
    put(8'h01); put(8'h03); put(8'h01);
    put(8'hDE); put(8'hAD); put(8'hBE);
    chk("wr_busy_mid", busy, 1'b1);
    put(8'hEF);
    chk("wr_staging3", dut.staging[3], 32'hDEADBEEF);
    chk("wr_active3_unchanged", conf_out[127:96], 32'h0);
    put(8'h21);
    chk("wr_status", status, 4'b0000);
    chk("wr_idle", busy, 1'b0);
    fs();
    put(8'h02);
    chk("commit_not_yet", commit_pulse, 1'b0);
    put(8'h02);
    chk("commit_pulse", commit_pulse, 1'b1);
    chk("commit_active3", conf_out[127:96], 32'hDEADBEEF);
    @(negedge clk);
    chk("commit_pulse_one_cycle", commit_pulse, 1'b0);

    // bad checksum write, rejected commit, clear restores staging
    fs();
    put(8'h01); put(8'h03); put(8'h01);
    put(8'h11); put(8'h22); put(8'h33); put(8'h44); put(8'h46);
    chk("badcs_status", status, 4'b0001);
    chk("badcs_staging_kept", dut.staging[3], 32'h11223344);
    fs();
    put(8'h02); put(8'h02);
    chk("rej_commit_pulse", commit_pulse, 1'b0);
    chk("rej_active3", conf_out[127:96], 32'hDEADBEEF);
    @(negedge clk);
    chk("rej_commit_pulse_late", commit_pulse, 1'b0);
    fs();
    put(8'h03); put(8'h03);
    chk("clear_status", status, 4'b0000);
    chk("clear_staging3", dut.staging[3], 32'hDEADBEEF);

    // address overrun: 15 + 2 > 16
    fs();
    put(8'h01); put(8'h0F); put(8'h02);
    for (int i = 0; i < 8; i++) put(8'h5A + 8'(i));
    chk("ovr_status", status, 4'b0010);
    chk("ovr_staging15", dut.staging[15], 32'h0);
    chk("ovr_busy", busy, 1'b1);
    fs();
    chk("ovr_busy_after_fs", busy, 1'b0);
    chk("ovr_status_after_fs", status, 4'b1010);
    fs();
    put(8'h03); put(8'h03);
    chk("ovr_clear", status, 4'b0000);

    // abort mid-word; new frame's command coincides with frame_start
    fs();
    put(8'h01); put(8'h05); put(8'h01); put(8'hAA); put(8'hBB);
    put_fs(8'h03);
    chk("abort_status", status, 4'b1000);
    chk("abort_busy_csum", busy, 1'b1);
    chk("abort_staging5", dut.staging[5], 32'h0);
    put(8'h03);
    chk("abort_clear_accepted", status, 4'b0000);
    chk("abort_staging5_after", dut.staging[5], 32'h0);

    // bad command
    fs();
    put(8'h7F);
    chk("badcmd_status", status, 4'b0100);
    chk("badcmd_busy", busy, 1'b1);
    put_fs(8'h03);
    put(8'h03);
    chk("badcmd_clear", status, 4'b0000);

    // back-to-back write of regs 0..2 followed directly by commit
    bulk = '{8'h01, 8'h00, 8'h03,
             8'h01, 8'h02, 8'h03, 8'h04,
             8'hA5, 8'hA5, 8'h5A, 8'h5A,
             8'hCA, 8'hFE, 8'hF0, 8'h0D,
             8'hCF, 8'h02, 8'h02};
    fs();
    for (int i = 0; i < 16; i++) put(bulk[i]);
    chk("b2b_status", status, 4'b0000);
    chk("b2b_conf_hold", conf_out[95:0], 96'h0);
    put(bulk[16]); put(bulk[17]);
    chk("b2b_commit_pulse", commit_pulse, 1'b1);
    chk("b2b_reg0", conf_out[31:0], 32'h01020304);
    chk("b2b_reg1", conf_out[63:32], 32'hA5A55A5A);
    chk("b2b_reg2", conf_out[95:64], 32'hCAFEF00D);
    chk("b2b_reg3", conf_out[127:96], 32'hDEADBEEF);

    // reset in the middle of a frame
    fs();
    put(8'h01); put(8'h00); put(8'h01); put(8'h55);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_busy", busy, 1'b0);
    chk("midrst_conf", conf_out, '0);
    chk("midrst_staging0", dut.staging[0], 32'h0);
    put(8'h02); put(8'h02);
    chk("midrst_commit", commit_pulse, 1'b1);
    chk("midrst_status", status, 4'b0000);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule

// File: doc/config_frame_receiver.md
CONFIG_FRAME_RECEIVER -- requirements
Module: config_frame_receiver

Interface
REQ-001 SHALL have parameter WIDTH, default 8, the byte width of the receiver stream.
REQ-002 SHALL have parameter WORD, default 32, the config register width; WORD%WIDTH==0 is required.
REQ-003 SHALL have parameter N_REGS, default 64, the register count; N_REGS<=2**WIDTH.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all logic is posedge.
REQ-005 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-006 SHALL have port sig_in, input, WIDTH bits: the byte from the SPI slave.
REQ-007 SHALL have port enable, input, 1 bit: a one-cycle strobe that marks sig_in valid.
REQ-008 SHALL have port frame_start, input, 1 bit: a one-cycle pulse at chip-select assert.
REQ-009 SHALL have port conf_out, output, N_REGS*WORD bits: the active bank; register i sits at [i*WORD +: WORD].
REQ-010 SHALL have port commit_pulse, output, 1 bit: high for 1 cycle when the active bank updates.
REQ-011 SHALL have port status, output, 4 bits: sticky {err_abort, err_cmd, err_addr, err_csum}, MSB first.
REQ-012 SHALL have port busy, output, 1 bit: high when the parser is not IDLE.

Function
REQ-013 SHALL keep two banks, staging and active, each N_REGS x WORD.
REQ-014 SHALL implement parser states IDLE, ADDR, COUNT, DATA, CSUM and DISCARD; a byte is consumed only on enable.
REQ-015 SHALL decode the IDLE byte as a command: 0x01 WRITE goes to ADDR; 0x02 COMMIT and 0x03 CLEAR go to CSUM; any other value sets err_cmd and goes to DISCARD.
REQ-016 SHALL latch the start index in ADDR and the word count in COUNT; index>=N_REGS, count==0 or index+count>N_REGS sets err_addr and goes to DISCARD.
REQ-017 SHALL assemble WORD/WIDTH data bytes in DATA, MSB first, and write staging[index+k] the cycle after the last byte of word k; partial words are never written.
REQ-018 SHALL enter CSUM after count words; the checksum byte makes the XOR of all frame bytes, including the command, equal 0.
REQ-019 SHALL set err_csum on a WRITE checksum mismatch; staging writes already made remain in place.
REQ-020 SHALL, on COMMIT with a good checksum and status==0, copy staging to active the cycle after the checksum byte, with commit_pulse high in that same cycle.
REQ-021 SHALL treat COMMIT as rejected when its checksum is bad or status!=0: active is unchanged, commit_pulse stays 0, and err_csum is set on a bad checksum.
REQ-022 SHALL, on CLEAR with a good checksum, copy active to staging and clear status to 0 the cycle after the checksum byte; a bad-checksum CLEAR sets err_csum.
REQ-023 SHALL return to IDLE after CSUM; DISCARD ignores all bytes until frame_start.
REQ-024 SHALL, on frame_start in any state other than IDLE, set err_abort, drop any partial word and return to IDLE.
REQ-025 SHALL, when frame_start and enable are coincident, reset the parser first and take sig_in as the new command byte.
REQ-026 SHALL accept an enable on every consecutive cycle with no stall and no backpressure.
REQ-027 SHALL hold conf_out constant except on a commit cycle.

Reset
REQ-028 SHALL, on rst, zero both banks, the status, the counters and the word assembler, and force commit_pulse=0, busy=0 and the parser to IDLE.
REQ-029 SHALL let rst mid-frame override everything; the next frame after rst is parsed from IDLE.

Verification (WIDTH=8, WORD=32, N_REGS=16)
REQ-030 SHALL cover reset: rst for 2 cycles -> conf_out=0, status=0, busy=0, commit_pulse=0.
REQ-031 SHALL cover write then commit: frame_start; bytes 01 03 01 DE AD BE EF 21 -> staging[3]=0xDEADBEEF and active unchanged; then 02 02 -> conf_out[127:96]=0xDEADBEEF with commit_pulse=1 for exactly one cycle.
REQ-032 SHALL cover a bad checksum: the same WRITE with checksum 20 -> status=0001; then 02 02 -> no commit_pulse and active[3] unchanged; then 03 03 -> status=0000 and staging[3]=active[3].
REQ-033 SHALL cover an address overrun: 01 0F 02 followed by 8 data bytes -> status=0010, no staging writes, busy=1 until frame_start.
REQ-034 SHALL cover an abort: frame_start after 01 05 01 AA BB -> status=1000, staging[5] unchanged, and the following frame 03 03 is accepted.
REQ-035 SHALL cover a bad command and back-to-back bytes: byte 7F -> status=0100; a full WRITE with enable high every cycle -> all words written correctly.
